csi2_hdr_ecc_decoder: RTL and testbench

CSI2_HDR_ECC_DECODER -- requirements
Module: csi2_hdr_ecc_decoder

---
 rtl/csi2_hdr_ecc_decoder.sv | 160 ++++++++++++++++
 tb/tb_csi2_hdr_ecc_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/csi2_hdr_ecc_decoder.sv
// CSI-2 packet-header ECC checker/corrector: two-stage pipeline with valid/ready handshake.
// Optional error counters are built when CSI2_HDR_ECC_CNT_EN is defined; otherwise they read as 0.
module csi2_hdr_ecc_decoder #(
  parameter int HDR_W = 24,  // 24 (v1.x) or 26 (v2.0 with VCX)
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [HDR_W-1:0] s_hdr_i,
  input  logic [7:0]       s_ecc_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [HDR_W-1:0] m_hdr_o,
  output logic             m_ok_o,
  output logic             m_corr_o,
  output logic             m_uncorr_o,
  output logic [4:0]       m_err_pos_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] uncorr_cnt_o
);

  // CSI-2 columns: the twenty weight-3 codes ascending, then the weight-5 codes ascending.
  function automatic logic [6*HDR_W-1:0] build_cols();
    logic [6*HDR_W-1:0] c;
    int                 n;
    c = '0;
    n = 0;
    for (int w = 3; w <= 5; w += 2) begin
      for (int v = 0; v < 64; v++) begin
        if ($countones(6'(v)) == w && n < HDR_W) begin
          c[6*n +: 6] = 6'(v);
          n++;
        end
      end
    end
    return c;
  endfunction

  // Syndrome -> {hit, data bit index}; misses carry index 5'h1F.
  function automatic logic [383:0] build_lut(input logic [6*HDR_W-1:0] cols);
    logic [383:0] t;
    for (int s = 0; s < 64; s++) t[6*s +: 6] = {1'b0, 5'h1F};
    for (int j = 0; j < HDR_W; j++) t[6*int'(cols[6*j +: 6]) +: 6] = {1'b1, 5'(j)};
    return t;
  endfunction

  localparam logic [6*HDR_W-1:0] COLS = build_cols();
  localparam logic [383:0]       LUT  = build_lut(COLS);

  logic             w_adv;
  logic [5:0]       w_ecc_calc;
  logic [5:0]       w_lut;
  logic [HDR_W-1:0] w_hdr;
  logic             w_ok, w_corr, w_uncorr;
  logic [4:0]       w_pos;
  logic             w_unused;

  logic             r_s1_valid;
  logic [HDR_W-1:0] r_s1_hdr;
  logic [5:0]       r_s1_syn;
  logic             r_m_valid;
  logic [HDR_W-1:0] r_m_hdr;
  logic             r_m_ok, r_m_corr, r_m_uncorr;
  logic [4:0]       r_m_pos;

  assign w_adv = !r_m_valid || m_ready_i;

  always_comb begin
    w_ecc_calc = '0;
    for (int j = 0; j < HDR_W; j++) begin
      if (s_hdr_i[j]) w_ecc_calc = w_ecc_calc ^ COLS[6*j +: 6];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_lut    = LUT[6*int'(r_s1_syn) +: 6];
    w_hdr    = r_s1_hdr;
    w_ok     = 1'b0;
    w_corr   = 1'b0;
    w_uncorr = 1'b0;
    w_pos    = 5'h1F;
    if (r_s1_syn == 6'h00) begin
      w_ok = 1'b1;
    end else if (w_lut[5]) begin
      w_corr = 1'b1;
      w_pos  = w_lut[4:0];
      w_hdr  = r_s1_hdr ^ (HDR_W'(1) << w_lut[4:0]);
    end else if ($onehot(r_s1_syn)) begin
      w_corr = 1'b1;  // error sits in the ECC byte itself; data already correct
    end else begin
      w_uncorr = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments; the synchronous reset lives inside the clocked block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_hdr   <= '0;
      r_s1_syn   <= '0;
      r_m_valid  <= 1'b0;
      r_m_hdr    <= '0;
      r_m_ok     <= 1'b0;
      r_m_corr   <= 1'b0;
      r_m_uncorr <= 1'b0;
      r_m_pos    <= 5'h1F;
    end else if (w_adv) begin
      r_s1_valid <= s_valid_i;
      r_s1_hdr   <= s_hdr_i;
      r_s1_syn   <= s_ecc_i[5:0] ^ w_ecc_calc;
      r_m_valid  <= r_s1_valid;
      if (r_s1_valid) begin
        r_m_hdr    <= w_hdr;
        r_m_ok     <= w_ok;
        r_m_corr   <= w_corr;
        r_m_uncorr <= w_uncorr;
        r_m_pos    <= w_pos;
      end
    end
  end

  assign s_ready_o   = w_adv;
  assign m_valid_o   = r_m_valid;
  assign m_hdr_o     = r_m_hdr;
  assign m_ok_o      = r_m_ok;
  assign m_corr_o    = r_m_corr;
  assign m_uncorr_o  = r_m_uncorr;
  assign m_err_pos_o = r_m_pos;

`ifdef CSI2_HDR_ECC_CNT_EN
  logic             w_acc;
  logic [CNT_W-1:0] r_corr_cnt, r_uncorr_cnt;

  assign w_acc = r_m_valid && m_ready_i;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_acc && r_m_corr && r_corr_cnt != '1) r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      if (w_acc && r_m_uncorr && r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
    end
  end

  assign corr_cnt_o   = r_corr_cnt;
  assign uncorr_cnt_o = r_uncorr_cnt;
  assign w_unused     = ^s_ecc_i[7:6];
`else
  assign corr_cnt_o   = '0;
  assign uncorr_cnt_o = '0;
  assign w_unused     = ^{s_ecc_i[7:6], clr_cnt_i};
`endif

endmodule

// File: tb/tb_csi2_hdr_ecc_decoder.sv
// Directed bench for csi2_hdr_ecc_decoder (HDR_W=24, CNT_W=2); counter expectations follow CSI2_HDR_ECC_CNT_EN.
module tb_csi2_hdr_ecc_decoder;

`ifdef CSI2_HDR_ECC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [2:0] F_OK = 3'b100, F_CORR = 3'b010, F_UNC = 3'b001;

  logic        clk_i = 1'b0;
  logic        rst_i, s_valid_i, m_ready_i, clr_cnt_i;
  logic        s_ready_o, m_valid_o, m_ok_o, m_corr_o, m_uncorr_o;
  logic [23:0] s_hdr_i, m_hdr_o;
  logic [7:0]  s_ecc_i;
  logic [4:0]  m_err_pos_o;
  logic [1:0]  corr_cnt_o, uncorr_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  csi2_hdr_ecc_decoder #(.HDR_W(24), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_hdr_i(s_hdr_i), .s_ecc_i(s_ecc_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_hdr_o(m_hdr_o), .m_ok_o(m_ok_o), .m_corr_o(m_corr_o), .m_uncorr_o(m_uncorr_o),
    .m_err_pos_o(m_err_pos_o), .clr_cnt_i(clr_cnt_i), .corr_cnt_o(corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [1:0] ec(input int n);
    return CNT_EN ? 2'(n) : 2'd0;
  endfunction

  // One header through an idle pipeline with the sink always ready.
  task automatic send(input string tag, input logic [23:0] hdr, input logic [7:0] ecc,
                      input logic [23:0] exp_hdr, input logic [2:0] exp_fl,
                      input logic [4:0] exp_pos, input int exp_cc, input int exp_uc);
    chk({tag, "_sready"}, s_ready_o, 1);
    s_valid_i = 1'b1;
    s_hdr_i   = hdr;
    s_ecc_i   = ecc;
    step();
    s_valid_i = 1'b0;
    chk({tag, "_lat1"}, m_valid_o, 0);
    step();
    chk({tag, "_valid"}, m_valid_o, 1);
    chk({tag, "_hdr"}, m_hdr_o, exp_hdr);
    chk({tag, "_flags"}, {m_ok_o, m_corr_o, m_uncorr_o}, exp_fl);
    chk({tag, "_pos"}, m_err_pos_o, exp_pos);
    step();
    chk({tag, "_nodup"}, m_valid_o, 0);
    chk({tag, "_ccnt"}, corr_cnt_o, ec(exp_cc));
    chk({tag, "_ucnt"}, uncorr_cnt_o, ec(exp_uc));
  endtask

  logic [23:0] bp_hdr   [4] = '{24'h000001, 24'h000002, 24'h000004, 24'h000000};
  logic [7:0]  bp_ecc   [4] = '{8'h07, 8'h0B, 8'h00, 8'h01};
  logic [23:0] bp_exp_h [4] = '{24'h000001, 24'h000002, 24'h000000, 24'h000000};
  logic [4:0]  bp_exp_p [4] = '{5'h1F, 5'h1F, 5'h02, 5'h1F};
  logic [2:0]  bp_exp_f [4] = '{F_OK, F_OK, F_CORR, F_CORR};

  initial begin
    int in_idx, out_idx, stalls;
    rst_i = 1'b1; s_valid_i = 1'b0; m_ready_i = 1'b1; clr_cnt_i = 1'b0;
    s_hdr_i = '0; s_ecc_i = '0;
    step();
    step();
    chk("rst_mvalid", m_valid_o, 0);
    chk("rst_sready", s_ready_o, 1);
    chk("rst_hdr", m_hdr_o, 0);
    chk("rst_pos", m_err_pos_o, 5'h1F);
    chk("rst_flags", {m_ok_o, m_corr_o, m_uncorr_o}, 0);
    chk("rst_cnts", {corr_cnt_o, uncorr_cnt_o}, 0);
    rst_i = 1'b0;
    step();

    send("clean",    24'h000000, 8'h00, 24'h000000, F_OK,   5'h1F, 0, 0);
    send("d0_err",   24'h000001, 8'h00, 24'h000000, F_CORR, 5'h00, 1, 0);
    send("ecc_err",  24'h000000, 8'h08, 24'h000000, F_CORR, 5'h1F, 2, 0);
    send("dbl_err",  24'h000003, 8'h00, 24'h000003, F_UNC,  5'h1F, 2, 1);
    send("good_d0",  24'h000001, 8'h07, 24'h000001, F_OK,   5'h1F, 2, 1);
    send("ecc_hi",   24'h000000, 8'hC0, 24'h000000, F_OK,   5'h1F, 2, 1);
    send("d23_err",  24'h800000, 8'h00, 24'h000000, F_CORR, 5'h17, 3, 1);
    send("w6_syn",   24'h000000, 8'h3F, 24'h000000, F_UNC,  5'h1F, 3, 2);
    send("ecc5_err", 24'h000000, 8'h20, 24'h000000, F_CORR, 5'h1F, 3, 2);
    send("d10_sat",  24'h000400, 8'h00, 24'h000000, F_CORR, 5'h0A, 3, 2);

    // Four back-to-back headers; sink stalls in cycles 3-5.
    in_idx = 0; out_idx = 0; stalls = 0;
    for (int c = 1; c <= 20; c++) begin
      m_ready_i = !(c >= 3 && c <= 5);
      s_valid_i = (in_idx < 4);
      if (in_idx < 4) begin
        s_hdr_i = bp_hdr[in_idx];
        s_ecc_i = bp_ecc[in_idx];
      end
      #1;
      if (m_valid_o && !m_ready_i && out_idx < 4) begin
        stalls++;
        chk("bp_sready_low", s_ready_o, 0);
        chk("bp_hold_hdr", m_hdr_o, bp_exp_h[out_idx]);
        chk("bp_hold_pos", m_err_pos_o, bp_exp_p[out_idx]);
      end
      if (m_valid_o && m_ready_i) begin
        if (out_idx < 4) begin
          chk("bp_hdr", m_hdr_o, bp_exp_h[out_idx]);
          chk("bp_pos", m_err_pos_o, bp_exp_p[out_idx]);
          chk("bp_flags", {m_ok_o, m_corr_o, m_uncorr_o}, bp_exp_f[out_idx]);
        end
        out_idx++;
      end
      if (s_valid_i && s_ready_o) in_idx++;
      step();
    end
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    chk("bp_in_count", in_idx, 4);
    chk("bp_out_count", out_idx, 4);
    chk("bp_stalls", stalls, 3);
    chk("bp_ccnt_sat", corr_cnt_o, ec(3));

    // Clear in the same cycle as accepting a corrected result.
    s_valid_i = 1'b1; s_hdr_i = 24'h000001; s_ecc_i = 8'h00;
    step();
    s_valid_i = 1'b0;
    step();
    chk("clr_valid", m_valid_o, 1);
    chk("clr_corr", m_corr_o, 1);
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    chk("clr_ccnt", corr_cnt_o, 0);
    chk("clr_ucnt", uncorr_cnt_o, 0);
    send("after_clr", 24'h000002, 8'h00, 24'h000000, F_CORR, 5'h01, 1, 0);

    // Reset while a header is in flight: nothing may emerge.
    s_valid_i = 1'b1; s_hdr_i = 24'h000003; s_ecc_i = 8'h00;
    step();
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_out", m_valid_o, 0);
      step();
    end
    chk("midrst_cnts", {corr_cnt_o, uncorr_cnt_o}, 0);
    chk("midrst_pos", m_err_pos_o, 5'h1F);
    send("post_rst", 24'h000001, 8'h00, 24'h000000, F_CORR, 5'h00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
